// File: rtl/des_sbox_feeder.sv
// DES f-function front end: latches R and the round subkey, drives E(R) xor K to the
// eight S-boxes and gathers their 4-bit results. Optional WAIT timeout: DES_FEEDER_TIMEOUT_EN.
module des_sbox_feeder #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Feeder_Start,
  input  logic [32:1] Feeder_R_Input,
  input  logic [48:1] Feeder_Subkey,
  output logic        Feeder_Busy,
  output logic        Feeder_Done,
  output logic        Feeder_Error,
  output logic [32:1] Feeder_Result,
  output logic [48:1] S_Box_Input_Bus,
  output logic        S_Box_Select,
  input  logic [8:1]  S_Box_Finish_Flags,
  input  logic [32:1] S_Box_Output_Bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
    $error("des_sbox_feeder: WAIT_LIMIT must be in 1..255");
  end

  // Vector index 33-n (R) / 49-n (K, bus) holds DES bit n; the E table repeats the
  // edge bits of each 4-bit nibble, wrapping bit 32 to the front and bit 1 to the end.
  function automatic logic [48:1] expand(input logic [32:1] r);
    logic [48:1] e;
    int          src;
    e = '0;
    for (int j = 1; j <= 48; j++) begin
      src = (((j - 1) / 6) * 4 + (j - 1) % 6 + 31) % 32 + 1;
      e[49 - j] = r[33 - src];
    end
    return e;
  endfunction

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_select;
  logic [32:1] r_result;
  logic [48:1] r_bus;
  logic [48:1] w_bus_next;
  logic        w_all_finished;

  assign w_bus_next     = expand(Feeder_R_Input) ^ Feeder_Subkey;
  assign w_all_finished = (S_Box_Finish_Flags == 8'hFF);

`ifdef DES_FEEDER_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic       r_error;
  logic [7:0] r_wait_cnt;
  logic       w_timed_out;

  assign w_timed_out = (r_wait_cnt == LIMIT);
`endif

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_select   <= 1'b0;
      r_result   <= '0;
      r_bus      <= '0;
`ifdef DES_FEEDER_TIMEOUT_EN
      r_error    <= 1'b0;
      r_wait_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Feeder_Start) begin
            r_bus    <= w_bus_next;
            r_busy   <= 1'b1;
            r_select <= 1'b1;
            r_state  <= ST_ISSUE;
`ifdef DES_FEEDER_TIMEOUT_EN
            r_error    <= 1'b0;
            r_wait_cnt <= '0;
`endif
          end
        end

        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_all_finished) begin
            r_result <= S_Box_Output_Bus;
            r_select <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
`ifdef DES_FEEDER_TIMEOUT_EN
          else if (w_timed_out) begin
            r_result <= '0;
            r_error  <= 1'b1;
            r_select <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy   <= 1'b0;
          r_select <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign Feeder_Busy     = r_busy;
  assign Feeder_Done     = r_done;
  assign Feeder_Result   = r_result;
  assign S_Box_Input_Bus = r_bus;
  assign S_Box_Select    = r_select;

`ifdef DES_FEEDER_TIMEOUT_EN
  assign Feeder_Error = r_error;
`else
  assign Feeder_Error = 1'b0;
`endif

endmodule
